pipe_stall_ctrl: RTL and testbench

Pipeline sequencing controller for the five-stage core: generates the write-enables and bubble/flush controls for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It sequences multi-cycle data-memory accesses issued from the EX/MEM stage, applies fetch stalls, load-use stalls and branch/jump flushes, and stops the pipeline on halt or on a data-memory timeout. It sits beside the hazard unit; its outputs drive the `write`/`en` inputs of the stage registers.

---
 rtl/pipe_stall_ctrl.sv | 144 ++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// Pipeline sequencing controller: stage-register enables, bubbles and flushes
// for the five-stage core, including multi-cycle data-memory waits and halt.
module pipe_stall_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             MemRead_EXMEM,
    input  logic             MemWrite_EXMEM,
    input  logic             Halt_EXMEM,
    input  logic             dmem_done,
    input  logic             imem_done,
    input  logic             load_use,
    input  logic             flush,
    output logic             dmem_en,
    output logic             en_IFID,
    output logic             en_IDEX,
    output logic             en_EXMEM,
    output logic             en_MEMWB,
    output logic             bubble_IDEX,
    output logic             bubble_MEMWB,
    output logic             flush_IFID,
    output logic             halted,
    output logic             err_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [WAIT_W-1:0] r_waitCnt;
    logic [WAIT_W-1:0] w_waitNext;
    logic              r_errTimeout;
    logic              w_errSet;
    logic [CNT_W-1:0]  r_stallCnt;
    logic              w_memop;
    logic              w_feHold;
    logic              w_feBubble;

    // Front-end decision shared by RUN and the DWAIT completion cycle; flush wins.
    assign w_memop    = MemRead_EXMEM | MemWrite_EXMEM;
    assign w_feHold   = !flush && (load_use || !imem_done);
    assign w_feBubble = flush || load_use || !imem_done;

    always_comb begin
        w_next       = r_state;
        w_waitNext   = r_waitCnt;
        w_errSet     = 1'b0;
        dmem_en      = 1'b0;
        en_IFID      = 1'b0;
        en_IDEX      = 1'b0;
        en_EXMEM     = 1'b0;
        en_MEMWB     = 1'b0;
        bubble_IDEX  = 1'b0;
        bubble_MEMWB = 1'b0;
        flush_IFID   = 1'b0;
        halted       = 1'b0;
        if (rst) begin
            case (r_state)
                RUN: begin
                    dmem_en = w_memop;
                    if (w_memop && !dmem_done) begin
                        en_MEMWB     = 1'b1;
                        bubble_MEMWB = 1'b1;
                        w_next       = DWAIT;
                        w_waitNext   = '0;
                    end else if (!w_memop && Halt_EXMEM) begin
                        en_IFID  = 1'b1;
                        en_IDEX  = 1'b1;
                        en_EXMEM = 1'b1;
                        en_MEMWB = 1'b1;
                        w_next   = HALT;
                    end else begin
                        en_IFID     = !w_feHold;
                        en_IDEX     = 1'b1;
                        en_EXMEM    = 1'b1;
                        en_MEMWB    = 1'b1;
                        bubble_IDEX = w_feBubble;
                        flush_IFID  = flush;
                    end
                end
                DWAIT: begin
                    // Completion releases the whole pipe at the same edge.
                    if (dmem_done) begin
                        en_IFID     = !w_feHold;
                        en_IDEX     = 1'b1;
                        en_EXMEM    = 1'b1;
                        en_MEMWB    = 1'b1;
                        bubble_IDEX = w_feBubble;
                        flush_IFID  = flush;
                        w_next      = RUN;
                        w_waitNext  = '0;
                    end else begin
                        en_MEMWB     = 1'b1;
                        bubble_MEMWB = 1'b1;
                        if (r_waitCnt == WAIT_LAST) begin
                            w_errSet = 1'b1;
                            w_next   = HALT;
                        end else begin
                            w_waitNext = r_waitCnt + 1'b1;
                        end
                    end
                end
                HALT: begin
                    halted = 1'b1;
                end
                default: begin
                    w_next = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= RUN;
            r_waitCnt    <= '0;
            r_errTimeout <= 1'b0;
            r_stallCnt   <= '0;
        end else begin
            r_state   <= w_next;
            r_waitCnt <= w_waitNext;
            if (w_errSet) begin
                r_errTimeout <= 1'b1;
            end
            if (!en_IFID && (r_stallCnt != '1)) begin
                r_stallCnt <= r_stallCnt + 1'b1;
            end
        end
    end

    assign err_timeout  = rst & r_errTimeout;
    assign stall_cycles = rst ? r_stallCnt : '0;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: directed test-plan sequences followed by
// randomized traffic, each cycle predicted by a rule-level reference model.
module tb_pipe_stall_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 6;
    localparam int STALL_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic             dmemEn;
        logic             enIFID;
        logic             enIDEX;
        logic             enEXMEM;
        logic             enMEMWB;
        logic             bubbleIDEX;
        logic             bubbleMEMWB;
        logic             flushIFID;
        logic             halted;
        logic             errTimeout;
        logic [CNT_W-1:0] stall;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             MemRead_EXMEM = 1'b0;
    logic             MemWrite_EXMEM = 1'b0;
    logic             Halt_EXMEM = 1'b0;
    logic             dmem_done = 1'b0;
    logic             imem_done = 1'b0;
    logic             load_use = 1'b0;
    logic             flush = 1'b0;
    logic             dmem_en;
    logic             en_IFID;
    logic             en_IDEX;
    logic             en_EXMEM;
    logic             en_MEMWB;
    logic             bubble_IDEX;
    logic             bubble_MEMWB;
    logic             flush_IFID;
    logic             halted;
    logic             err_timeout;
    logic [CNT_W-1:0] stall_cycles;

    int   checkCount = 0;
    int   passCount  = 0;
    int   cycleNum   = 0;
    exp_t sbQueue[$];

    // Reference model: spec-level view of the controller's condition.
    bit mWaiting    = 1'b0;
    bit mStopped    = 1'b0;
    bit mErr        = 1'b0;
    int mWaitCycles = 0;
    int mStallTotal = 0;

    pipe_stall_ctrl #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .MemRead_EXMEM  (MemRead_EXMEM),
        .MemWrite_EXMEM (MemWrite_EXMEM),
        .Halt_EXMEM     (Halt_EXMEM),
        .dmem_done      (dmem_done),
        .imem_done      (imem_done),
        .load_use       (load_use),
        .flush          (flush),
        .dmem_en        (dmem_en),
        .en_IFID        (en_IFID),
        .en_IDEX        (en_IDEX),
        .en_EXMEM       (en_EXMEM),
        .en_MEMWB       (en_MEMWB),
        .bubble_IDEX    (bubble_IDEX),
        .bubble_MEMWB   (bubble_MEMWB),
        .flush_IFID     (flush_IFID),
        .halted         (halted),
        .err_timeout    (err_timeout),
        .stall_cycles   (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic modelCycle(input logic r, input logic mr, input logic mw, input logic hl,
                              input logic dd, input logic id, input logic lu, input logic fl,
                              output exp_t e);
        bit memop;
        bit hold;
        bit bub;
        e = '0;
        if (!r) begin
            mWaiting    = 1'b0;
            mStopped    = 1'b0;
            mErr        = 1'b0;
            mWaitCycles = 0;
            mStallTotal = 0;
            return;
        end
        memop = mr || mw;
        hold  = !fl && (lu || !id);
        bub   = fl || lu || !id;
        e.errTimeout = mErr;
        e.stall      = CNT_W'((mStallTotal > STALL_MAX) ? STALL_MAX : mStallTotal);
        if (mStopped) begin
            e.halted = 1'b1;
        end else if (mWaiting) begin
            if (dd) begin
                e.enIFID = !hold; e.enIDEX = 1'b1; e.enEXMEM = 1'b1; e.enMEMWB = 1'b1;
                e.bubbleIDEX = bub; e.flushIFID = fl;
                mWaiting = 1'b0;
            end else begin
                e.enMEMWB = 1'b1; e.bubbleMEMWB = 1'b1;
                mWaitCycles++;
                if (mWaitCycles == TIMEOUT) begin
                    mErr = 1'b1; mStopped = 1'b1; mWaiting = 1'b0;
                end
            end
        end else begin
            e.dmemEn = memop;
            if (memop && !dd) begin
                e.enMEMWB = 1'b1; e.bubbleMEMWB = 1'b1;
                mWaiting = 1'b1; mWaitCycles = 0;
            end else if (!memop && hl) begin
                e.enIFID = 1'b1; e.enIDEX = 1'b1; e.enEXMEM = 1'b1; e.enMEMWB = 1'b1;
                mStopped = 1'b1;
            end else begin
                e.enIFID = !hold; e.enIDEX = 1'b1; e.enEXMEM = 1'b1; e.enMEMWB = 1'b1;
                e.bubbleIDEX = bub; e.flushIFID = fl;
            end
        end
        if (!e.enIFID) mStallTotal++;
    endtask

    // Argument order: rst, MemRead, MemWrite, Halt, dmem_done, imem_done, load_use, flush.
    task automatic applyStimulus(input logic r, input logic mr, input logic mw, input logic hl,
                                 input logic dd, input logic id, input logic lu, input logic fl);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; MemRead_EXMEM = mr; MemWrite_EXMEM = mw; Halt_EXMEM = hl;
        dmem_done = dd; imem_done = id; load_use = lu; flush = fl;
        modelCycle(r, mr, mw, hl, dd, id, lu, fl, e);
        sbQueue.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [9:0] act;
        logic [9:0] req;
        act = {dmem_en, en_IFID, en_IDEX, en_EXMEM, en_MEMWB, bubble_IDEX, bubble_MEMWB,
               flush_IFID, halted, err_timeout};
        req = {e.dmemEn, e.enIFID, e.enIDEX, e.enEXMEM, e.enMEMWB, e.bubbleIDEX, e.bubbleMEMWB,
               e.flushIFID, e.halted, e.errTimeout};
        checkCount++;
        if (act === req) passCount++;
        else $display("[TB] FAIL ctrl cycle %0d: got %b expected %b (dmem_en,en_IFID,en_IDEX,en_EXMEM,en_MEMWB,bubble_IDEX,bubble_MEMWB,flush_IFID,halted,err)",
                      cycleNum, act, req);
        checkCount++;
        if (stall_cycles === e.stall) passCount++;
        else $display("[TB] FAIL stall_cycles cycle %0d: got %0d expected %0d", cycleNum, stall_cycles, e.stall);
    endtask

    // Monitor: every cycle the controller presents a full set of outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbQueue.size() > 0) begin
                e = sbQueue.pop_front();
                checkOutput(e);
                cycleNum++;
            end
        end
    end

    initial begin
        int doneBias;
        logic r, mr, mw, hl, dd, id, lu, fl;
        int sel;
        $display("[TB] starting pipe_stall_ctrl bench");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
        // Load hit, then idle.
        applyStimulus(1, 1, 0, 0, 1, 1, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 0);
        // Store completing three cycles after issue.
        applyStimulus(1, 0, 1, 0, 0, 1, 0, 0);
        applyStimulus(1, 0, 1, 0, 0, 1, 0, 0);
        applyStimulus(1, 0, 1, 0, 0, 1, 0, 0);
        applyStimulus(1, 0, 1, 0, 1, 1, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 0);
        // flush overriding load_use, then load_use alone, then fetch stall.
        applyStimulus(1, 0, 0, 0, 0, 1, 1, 1);
        applyStimulus(1, 0, 0, 0, 0, 1, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 0);
        // Stray dmem_done without memop is ignored.
        applyStimulus(1, 0, 0, 0, 1, 1, 0, 0);
        // Load that never completes: timeout into HALT.
        for (int i = 0; i < 8; i++) applyStimulus(1, 1, 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 0);
        // Halt, then sit stopped long enough to saturate the stall counter.
        applyStimulus(1, 0, 0, 1, 0, 1, 0, 0);
        for (int i = 0; i < STALL_MAX + 6; i++) applyStimulus(1, 1, 0, 0, 1, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 0);
        // Reset in the second wait cycle, then a stray done.
        applyStimulus(1, 1, 0, 0, 0, 1, 0, 0);
        applyStimulus(1, 1, 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 1, 0, 0);
        applyStimulus(1, 0, 0, 0, 1, 1, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 0);

        doneBias = 50;
        for (int n = 0; n < 1500; n++) begin
            if ((n % 40) == 0) begin
                sel = $urandom_range(0, 2);
                doneBias = (sel == 0) ? 10 : ((sel == 1) ? 50 : 90);
            end
            r   = ($urandom_range(0, 99) >= 2);
            sel = $urandom_range(0, 99);
            mr  = (sel < 12);
            mw  = (sel >= 12 && sel < 20);
            hl  = ($urandom_range(0, 99) == 0);
            dd  = ($urandom_range(0, 99) < doneBias);
            id  = ($urandom_range(0, 99) < 80);
            lu  = ($urandom_range(0, 99) < 20);
            fl  = ($urandom_range(0, 99) < 15);
            applyStimulus(r, mr, mw, hl, dd, id, lu, fl);
        end

        for (int i = 0; i < 10 && sbQueue.size() > 0; i++) @(negedge clk);
        #1;
        checkCount++;
        if (sbQueue.size() == 0) passCount++;
        else $display("[TB] FAIL scoreboard drain: got %0d pending expected 0", sbQueue.size());
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
